// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the regfile_mp register file.
//   state_t        - clear-sweep FSM states (IDLE, CLEAR)
//   DEFAULT_DATA_W - default entry width
//   DEFAULT_DEPTH  - default number of entries
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_DEPTH  = 8;

endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: background clear sweep controller for regfile_mp.
// Ports:
//   clk        - clock, all state on posedge
//   reset      - asynchronous active-high reset
//   clr_req    - single-cycle request to zero all entries (honoured in IDLE)
//   busy       - registered, high while the sweep runs (exactly DEPTH cycles)
//   sweep_en   - array write enable for the sweep (high in CLEAR)
//   sweep_addr - entry being zeroed this cycle
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_req,
   output logic              busy,
   output logic              sweep_en,
   output logic [ADDR_W-1:0] sweep_addr
);

   state_t            state;
   logic [ADDR_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clr_req) begin
                  state <= CLEAR;
                  count <= '0;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               if (count == ADDR_W'(DEPTH - 1)) begin
                  state <= IDLE;
                  count <= '0;
                  busy  <= 1'b0;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               count <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign sweep_en   = (state == CLEAR);
   assign sweep_addr = count;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: DEPTH x DATA_W register file, one write port, two registered
// read ports, background clear sweep, optional hardwired-zero entry 0.
// Compile-time option: define REGFILE_BYPASS_EN for write-first forwarding
// of same-cycle writes to the read ports; otherwise read-first.
// Ports:
//   clk, reset         - clock; asynchronous active-high reset to zero
//   wr_en/addr/data    - write port (dropped when out of range, zero entry,
//                        or while the clear sweep runs)
//   rd_addr1/rd_data1  - read port 1, 1-cycle registered
//   rd_addr2/rd_data2  - read port 2, 1-cycle registered
//   clr_req            - single-cycle request to zero all entries
//   busy               - high while the clear sweep runs
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   input  logic              clr_req,
   output logic              busy
);

   localparam int unsigned N = DEPTH;

   logic [DATA_W-1:0] mem [N];
   logic              sweep_en;
   logic [ADDR_W-1:0] sweep_addr;
   logic              wr_ok;
   logic [DATA_W-1:0] rd_next1;
   logic [DATA_W-1:0] rd_next2;

   regfile_clear_fsm #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clear_fsm (
      .clk        (clk),
      .reset      (reset),
      .clr_req    (clr_req),
      .busy       (busy),
      .sweep_en   (sweep_en),
      .sweep_addr (sweep_addr)
   );

   // A write that will actually land in the array; only these are forwarded.
   assign wr_ok = wr_en && !sweep_en && (32'(wr_addr) < N) &&
                  !((ZERO_REG != 0) && (wr_addr == '0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < N; i++) mem[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            if (sweep_en && sweep_addr == ADDR_W'(i))
               mem[i] <= '0;
            else if (wr_ok && wr_addr == ADDR_W'(i))
               mem[i] <= wr_data;
         end
      end
   end

   // Out-of-range addresses match no entry and therefore read as zero.
   always_comb begin
      rd_next1 = '0;
      rd_next2 = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (rd_addr1 == ADDR_W'(i)) rd_next1 = mem[i];
         if (rd_addr2 == ADDR_W'(i)) rd_next2 = mem[i];
      end
      if ((ZERO_REG != 0) && (rd_addr1 == '0)) rd_next1 = '0;
      if ((ZERO_REG != 0) && (rd_addr2 == '0)) rd_next2 = '0;
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr1)) rd_next1 = wr_data;
      if (wr_ok && (wr_addr == rd_addr2)) rd_next2 = wr_data;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data1 <= '0;
         rd_data2 <= '0;
      end else begin
         rd_data1 <= rd_next1;
         rd_data2 <= rd_next2;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp.
// u_dut: default DEPTH=8, ZERO_REG=0. u_zr: DEPTH=6, ZERO_REG=1.
module tb_regfile_mp;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en, clr_req;
   logic [2:0] wr_addr, rd_addr1, rd_addr2;
   logic [7:0] wr_data, rd_data1, rd_data2;
   logic       busy;

   logic       z_wr_en, z_clr_req;
   logic [2:0] z_wr_addr, z_rd_addr1, z_rd_addr2;
   logic [7:0] z_wr_data, z_rd_data1, z_rd_data2;
   logic       z_busy;

   int total = 0;
   int bad   = 0;
   int n;

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(8), .DEPTH(8), .ZERO_REG(0)) u_dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2), .clr_req(clr_req),
      .busy(busy)
   );

   regfile_mp #(.DATA_W(8), .DEPTH(6), .ZERO_REG(1)) u_zr (
      .clk(clk), .reset(reset), .wr_en(z_wr_en), .wr_addr(z_wr_addr),
      .wr_data(z_wr_data), .rd_addr1(z_rd_addr1), .rd_addr2(z_rd_addr2),
      .rd_data1(z_rd_data1), .rd_data2(z_rd_data2), .clr_req(z_clr_req),
      .busy(z_busy)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic zwr(input logic [2:0] a, input logic [7:0] d);
      z_wr_en = 1'b1; z_wr_addr = a; z_wr_data = d;
      tick();
      z_wr_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; clr_req = 1'b0;
      wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;
      z_wr_en = 1'b0; z_clr_req = 1'b0;
      z_wr_addr = '0; z_wr_data = '0; z_rd_addr1 = '0; z_rd_addr2 = '0;
      tick(); tick();
      check("rst_rd1", rd_data1, 8'h00);
      check("rst_rd2", rd_data2, 8'h00);
      check("rst_busy", busy, 1'b0);
      reset = 1'b0;

      // Reset contents: every entry reads zero on both ports.
      for (int a = 0; a < 8; a++) begin
         rd_addr1 = 3'(a); rd_addr2 = 3'(7 - a);
         tick();
         check("rst_mem1", rd_data1, 8'h00);
         check("rst_mem2", rd_data2, 8'h00);
      end
      check("idle_busy", busy, 1'b0);

      // Basic write then read.
      wr(3'd3, 8'hA5);
      rd_addr1 = 3'd3;
      tick();
      check("wr_rd_a5", rd_data1, 8'hA5);

      // Same-cycle write/read to addr 5 holding 0x11.
      wr(3'd5, 8'h11);
      rd_addr2 = 3'd5;
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
      tick();
      wr_en = 1'b0;
`ifdef REGFILE_BYPASS_EN
      check("fwd_same", rd_data2, 8'h3C);
`else
      check("fwd_same", rd_data2, 8'h11);
`endif
      tick();
      check("fwd_after", rd_data2, 8'h3C);

      // Fill with 0xFF, sweep, writes during busy are dropped.
      for (int a = 0; a < 8; a++) wr(3'(a), 8'hFF);
      rd_addr1 = 3'd6;
      tick();
      check("fill_ff", rd_data1, 8'hFF);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      check("busy_rise", busy, 1'b1);
      n = 0;
      while (busy && n < 20) begin
         wr_en = 1'b1; wr_addr = 3'(n % 8); wr_data = 8'h55;
         tick();
         n++;
      end
      wr_en = 1'b0;
      check("busy_len", n, 8);
      for (int a = 0; a < 8; a++) begin
         rd_addr1 = 3'(a); rd_addr2 = 3'(a);
         tick();
         check("clr_rd1", rd_data1, 8'h00);
         check("clr_rd2", rd_data2, 8'h00);
      end

      // Write accepted again once idle.
      wr(3'd1, 8'h96);
      rd_addr1 = 3'd1;
      tick();
      check("post_clr_wr", rd_data1, 8'h96);

      // Reset mid-sweep.
      wr(3'd2, 8'h5A);
      wr(3'd7, 8'h99);
      rd_addr1 = 3'd2;
      tick();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick(); tick(); tick();
      check("mid_busy", busy, 1'b1);
      check("mid_rd_old", rd_data1, 8'h5A);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_rd1", rd_data1, 8'h00);
      tick();
      reset = 1'b0;
      rd_addr1 = 3'd7;
      tick();
      check("mid_rst_mem", rd_data1, 8'h00);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      check("resweep_len", n, 8);

      // Zero register and DEPTH=6 instance.
      zwr(3'd0, 8'h77);
      z_rd_addr1 = 3'd0;
      tick();
      check("zr_addr0", z_rd_data1, 8'h00);
      zwr(3'd1, 8'h66);
      zwr(3'd5, 8'h12);
      zwr(3'd7, 8'h42);
      z_rd_addr1 = 3'd7; z_rd_addr2 = 3'd5;
      tick();
      check("zr_oor_rd", z_rd_data1, 8'h00);
      check("zr_alias5", z_rd_data2, 8'h12);
      z_rd_addr1 = 3'd1;
      tick();
      check("zr_addr1", z_rd_data1, 8'h66);
      // Same-cycle dropped write to the zero entry is never forwarded.
      z_rd_addr2 = 3'd0;
      z_wr_en = 1'b1; z_wr_addr = 3'd0; z_wr_data = 8'hEE;
      tick();
      z_wr_en = 1'b0;
      check("zr_nofwd", z_rd_data2, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
